branch_redirect: RTL

Program-counter and redirect sequencer that consumes the taken/not-taken `branch` outcome from the branch comparator. It holds the fetch PC and advances it each cycle. On a taken branch it loads the computed target and kills the wrong-path instructions already in flight. It sits between the execute-stage comparator and the fetch stage.

---
 rtl/branch_redirect_if.sv | 32 +++
 rtl/branch_redirect.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/branch_redirect_if.sv
// Handshake bundle between the EX branch comparator, the PC sequencer and fetch.
// The stats counters are always present so the port list does not depend on configuration.
interface branch_redirect_if #(
  parameter int PC_WIDTH     = 16,
  parameter int OFFSET_WIDTH = 8
);
  logic                    stall;
  logic                    branch_valid;
  logic                    branch;
  logic [PC_WIDTH-1:0]     branch_pc;
  logic [OFFSET_WIDTH-1:0] branch_offset;
  logic [PC_WIDTH-1:0]     pc;
  logic                    redirect;
  logic                    flush;
  logic                    busy;
  logic [15:0]             taken_count;
  logic [15:0]             branch_count;

  modport master (
    output stall, branch_valid, branch,
    output branch_pc, branch_offset,
    input  pc, redirect, flush, busy,
    input  taken_count, branch_count
  );

  modport slave (
    input  stall, branch_valid, branch,
    input  branch_pc, branch_offset,
    output pc, redirect, flush, busy,
    output taken_count, branch_count
  );
endinterface

// File: rtl/branch_redirect.sv
// Fetch PC sequencer: increments the PC, redirects on taken branches and flushes IF/ID.
// Optional BRANCH_STATS_EN adds saturating taken/total branch counters.
module branch_redirect #(
  parameter int                  PC_WIDTH     = 16,
  parameter int                  OFFSET_WIDTH = 8,
  parameter int                  FLUSH_STAGES = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
  input logic         clk,
  input logic         rst,
  branch_redirect_if.slave bus
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [2:0] LP_CNT_INIT = 3'(FLUSH_STAGES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_cnt;
  logic [2:0]          w_cnt_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic                r_redirect;
  logic                w_redirect_nxt;
  logic                r_flush;
  logic                w_flush_nxt;

  logic                w_accept;
  logic                w_take;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_off_sext;
  logic [PC_WIDTH-1:0] w_target;

  assign w_accept = (r_state == ST_RUN) && !bus.stall
                    && bus.branch_valid;
  assign w_take   = w_accept && bus.branch;
  assign w_pc_inc = r_pc + PC_WIDTH'(1);

  assign w_off_sext = {
    {(PC_WIDTH-OFFSET_WIDTH){bus.branch_offset[OFFSET_WIDTH-1]}},
    bus.branch_offset
  };
  // Target is relative to the instruction after the branch.
  assign w_target = bus.branch_pc + PC_WIDTH'(1) + w_off_sext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN: begin
        if (w_take) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!bus.stall && r_cnt == 3'd0) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_pc_nxt       = r_pc;
    w_redirect_nxt = 1'b0;
    w_flush_nxt    = r_flush;
    w_cnt_nxt      = r_cnt;
    unique case (r_state)
      ST_RUN: begin
        if (w_take) begin
          w_pc_nxt       = w_target;
          w_redirect_nxt = 1'b1;
          w_flush_nxt    = 1'b1;
          w_cnt_nxt      = LP_CNT_INIT;
        end else if (!bus.stall) begin
          w_pc_nxt = w_pc_inc;
        end
      end
      ST_FLUSH: begin
        if (!bus.stall) begin
          w_pc_nxt = w_pc_inc;
          if (r_cnt == 3'd0) begin
            w_flush_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
          end
        end
      end
      default: begin
        w_flush_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_redirect <= 1'b0;
      r_flush    <= 1'b0;
      r_cnt      <= 3'd0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_redirect <= w_redirect_nxt;
      r_flush    <= w_flush_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign bus.pc       = r_pc;
  assign bus.redirect = r_redirect;
  assign bus.flush    = r_flush;
  assign bus.busy     = (r_state == ST_FLUSH);

`ifdef BRANCH_STATS_EN
  logic [15:0] r_taken_cnt;
  logic [15:0] r_branch_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taken_cnt  <= 16'd0;
      r_branch_cnt <= 16'd0;
    end else begin
      if (w_accept && r_branch_cnt != 16'hFFFF) begin
        r_branch_cnt <= r_branch_cnt + 16'd1;
      end
      if (w_take && r_taken_cnt != 16'hFFFF) begin
        r_taken_cnt <= r_taken_cnt + 16'd1;
      end
    end
  end

  assign bus.taken_count  = r_taken_cnt;
  assign bus.branch_count = r_branch_cnt;
`else
  assign bus.taken_count  = 16'd0;
  assign bus.branch_count = 16'd0;
`endif

endmodule
